// File: rtl/periph_packet_router_pkg.sv
// Shared widths and payload types for the peripheral packet router.
// Host packets are {addr, payload}; the address selects a peripheral.
package periph_packet_router_pkg;

    localparam int unsigned usb_packet_width     = 32;
    localparam int unsigned periph_address_width = 3;
    localparam int unsigned periph_payload_width = usb_packet_width - periph_address_width;
    localparam int unsigned drop_count_width     = 8;

    typedef logic [periph_payload_width-1:0] periph_payload_t;
    typedef logic [periph_address_width-1:0] periph_addr_t;

    typedef struct packed {
        periph_addr_t    addr;
        periph_payload_t payload;
    } usb_packet_t;

    // Index width for an n-entry one-hot vector (never zero).
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/periph_packet_router_rr_arbiter.sv
// Round-robin arbiter. Searches from the entry after the last grant.
// Ports:
//   clk, rst   clock, async active-high reset (last grant -> N-1)
//   req        request vector
//   advance    commit the current grant as the new last grant
//   grant_oh   one-hot grant (combinational)
//   grant_idx  index of the grant (combinational)
//   any        some request is present
module rr_arbiter
    import periph_packet_router_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N-1:0]                 req,
    input  logic                         advance,
    output logic [N-1:0]                 grant_oh,
    output logic [idx_width(N)-1:0]      grant_idx,
    output logic                         any
);

    localparam int unsigned IW = idx_width(N);

    logic [IW-1:0] last_grant;
    int unsigned   cand;

    // First requester in last_grant+1 .. last_grant+N, wrapping mod N.
    always_comb begin
        grant_oh  = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            cand = 32'(last_grant) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!any && req[IW'(cand)]) begin
                any                 = 1'b1;
                grant_idx           = IW'(cand);
                grant_oh[IW'(cand)] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= IW'(N - 1);
        end else if (advance && any) begin
            last_grant <= grant_idx;
        end
    end

endmodule

// File: rtl/periph_packet_router.sv
// Routes host packets to peripheral tx FIFOs by address and merges
// peripheral rx FIFOs (round-robin) into the host-bound FIFO, tagging
// each word with its source address. All FIFOs are first-word-fall-through.
// Ports:
//   clk, rst                          clock, async active-high reset
//   usb_rx_data/empty/rden            host->device FIFO head / pop
//   periph_tx_data/wren/full          payload broadcast, one-hot write, full
//   periph_rx_data/empty/rden         peripheral rx FIFO heads / one-hot pop
//   usb_tx_data/wren/full             device->host FIFO write side
//   drop_count                        saturating invalid-address count
//   idle                              nothing staged, all sources empty
module periph_packet_router
    import periph_packet_router_pkg::*;
#(
    parameter int unsigned NUM_PERIPHS = 8
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [usb_packet_width-1:0]                       usb_rx_data,
    input  logic                                              usb_rx_empty,
    output logic                                              usb_rx_rden,
    output logic [NUM_PERIPHS-1:0][periph_payload_width-1:0]  periph_tx_data,
    output logic [NUM_PERIPHS-1:0]                            periph_tx_wren,
    input  logic [NUM_PERIPHS-1:0]                            periph_tx_full,
    input  logic [NUM_PERIPHS-1:0][periph_payload_width-1:0]  periph_rx_data,
    input  logic [NUM_PERIPHS-1:0]                            periph_rx_empty,
    output logic [NUM_PERIPHS-1:0]                            periph_rx_rden,
    output logic [usb_packet_width-1:0]                       usb_tx_data,
    output logic                                              usb_tx_wren,
    input  logic                                              usb_tx_full,
    output logic [drop_count_width-1:0]                       drop_count,
    output logic                                              idle
);

    localparam int unsigned IW = idx_width(NUM_PERIPHS);
    localparam logic [periph_address_width:0] NUM_P = (periph_address_width + 1)'(NUM_PERIPHS);

    // ---------------- downstream: host -> peripheral ----------------
    usb_packet_t     rx_pkt;
    logic            rx_addr_ok;
    logic            dn_valid;
    periph_addr_t    dn_addr;
    periph_payload_t dn_payload;
    logic            drain;

    assign rx_pkt     = usb_packet_t'(usb_rx_data);
    assign rx_addr_ok = ({1'b0, rx_pkt.addr} < NUM_P);

    for (genvar g = 0; g < NUM_PERIPHS; g++) begin : g_tx_wren
        assign periph_tx_wren[g] = dn_valid & (dn_addr == periph_address_width'(g))
                                 & ~periph_tx_full[g];
    end

    assign periph_tx_data = {NUM_PERIPHS{dn_payload}};
    assign drain          = |periph_tx_wren;
    // Gated by rst: the host FIFO is not cleared by our reset.
    assign usb_rx_rden    = ~rst & ~usb_rx_empty & (~dn_valid | drain);

    // Invalid addresses are popped and dropped; the stage empties behind them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dn_valid   <= 1'b0;
            dn_addr    <= '0;
            dn_payload <= '0;
            drop_count <= '0;
        end else if (usb_rx_rden) begin
            dn_valid <= rx_addr_ok;
            if (rx_addr_ok) begin
                dn_addr    <= rx_pkt.addr;
                dn_payload <= rx_pkt.payload;
            end else if (drop_count != '1) begin
                drop_count <= drop_count + drop_count_width'(1);
            end
        end else if (drain) begin
            dn_valid <= 1'b0;
        end
    end

    // ---------------- upstream: peripheral -> host ----------------
    logic                   up_valid;
    usb_packet_t            up_data;
    usb_packet_t            rd_pkt;
    logic                   up_load;
    logic                   arb_advance;
    logic [NUM_PERIPHS-1:0] arb_grant_oh;
    logic [IW-1:0]          arb_idx;
    logic                   arb_any;

    assign usb_tx_wren = up_valid & ~usb_tx_full;
    assign usb_tx_data = up_data;
    assign up_load     = ~up_valid | usb_tx_wren;
    assign arb_advance = up_load & ~rst;

    rr_arbiter #(
        .N (NUM_PERIPHS)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (~periph_rx_empty),
        .advance   (arb_advance),
        .grant_oh  (arb_grant_oh),
        .grant_idx (arb_idx),
        .any       (arb_any)
    );

    assign periph_rx_rden = arb_advance ? arb_grant_oh : '0;
    assign rd_pkt         = '{addr: periph_address_width'(arb_idx),
                              payload: periph_rx_data[arb_idx]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            up_valid <= 1'b0;
            up_data  <= '0;
        end else if (up_load) begin
            up_valid <= arb_any;
            if (arb_any) begin
                up_data <= rd_pkt;
            end
        end
    end

    assign idle = ~dn_valid & ~up_valid & usb_rx_empty & (&periph_rx_empty);

endmodule

// File: tb/tb_periph_packet_router.sv
// Bench for periph_packet_router: FWFT FIFO models around an 8-peripheral
// instance with per-peripheral and host-bound scoreboards, plus a
// 4-peripheral instance for invalid-address handling.
module tb_periph_packet_router;
    import periph_packet_router_pkg::*;

    localparam int unsigned NP  = 8;
    localparam int unsigned NP4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [31:0]         usb_rx_data;
    logic                usb_rx_empty, usb_rx_rden;
    logic [NP-1:0][28:0] periph_tx_data;
    logic [NP-1:0]       periph_tx_wren, periph_tx_full;
    logic [NP-1:0][28:0] periph_rx_data;
    logic [NP-1:0]       periph_rx_empty, periph_rx_rden;
    logic [31:0]         usb_tx_data;
    logic                usb_tx_wren, usb_tx_full;
    logic [7:0]          drop_count;
    logic                idle;

    logic [31:0]          usb4_rx_data;
    logic                 usb4_rx_empty, usb4_rx_rden;
    logic [NP4-1:0][28:0] tx4_data;
    logic [NP4-1:0]       tx4_wren;
    logic [NP4-1:0][28:0] rx4_data;
    logic [NP4-1:0]       rx4_rden;
    logic [31:0]          usb4_tx_data;
    logic                 usb4_tx_wren;
    logic [7:0]           drop4;
    logic                 idle4;

    periph_packet_router #(.NUM_PERIPHS(NP)) dut (
        .clk(clk), .rst(rst),
        .usb_rx_data(usb_rx_data), .usb_rx_empty(usb_rx_empty), .usb_rx_rden(usb_rx_rden),
        .periph_tx_data(periph_tx_data), .periph_tx_wren(periph_tx_wren), .periph_tx_full(periph_tx_full),
        .periph_rx_data(periph_rx_data), .periph_rx_empty(periph_rx_empty), .periph_rx_rden(periph_rx_rden),
        .usb_tx_data(usb_tx_data), .usb_tx_wren(usb_tx_wren), .usb_tx_full(usb_tx_full),
        .drop_count(drop_count), .idle(idle)
    );

    assign rx4_data = '0;

    periph_packet_router #(.NUM_PERIPHS(NP4)) dut4 (
        .clk(clk), .rst(rst),
        .usb_rx_data(usb4_rx_data), .usb_rx_empty(usb4_rx_empty), .usb_rx_rden(usb4_rx_rden),
        .periph_tx_data(tx4_data), .periph_tx_wren(tx4_wren), .periph_tx_full(4'b0000),
        .periph_rx_data(rx4_data), .periph_rx_empty(4'b1111), .periph_rx_rden(rx4_rden),
        .usb_tx_data(usb4_tx_data), .usb_tx_wren(usb4_tx_wren), .usb_tx_full(1'b0),
        .drop_count(drop4), .idle(idle4)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] usbq[$];
    logic [28:0] rxq[NP][$];
    logic [28:0] exp_tx[NP][$];
    logic [31:0] exp_up[$];
    logic        usb_pop;
    logic [NP-1:0] rx_pop;

    typedef struct {
        logic [2:0]  addr;
        logic [28:0] payload;
        logic [7:0]  exp_wren;
    } dn_vec_t;
    dn_vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic refresh();
        usb_rx_empty = (usbq.size() == 0);
        usb_rx_data  = (usbq.size() != 0) ? usbq[0] : 32'h0;
        for (int i = 0; i < NP; i++) begin
            periph_rx_empty[i] = (rxq[i].size() == 0);
            periph_rx_data[i]  = (rxq[i].size() != 0) ? rxq[i][0] : 29'h0;
        end
    endtask

    task automatic push_usb(input logic [2:0] a, input logic [28:0] p);
        usbq.push_back({a, p});
        exp_tx[a].push_back(p);
        refresh();
    endtask

    // Call order is the predicted round-robin output order.
    task automatic push_rx(input int i, input logic [28:0] d);
        rxq[i].push_back(d);
        exp_up.push_back({3'(i), d});
        refresh();
    endtask

    task automatic clear_all();
        usbq.delete();
        exp_up.delete();
        for (int i = 0; i < NP; i++) begin
            rxq[i].delete();
            exp_tx[i].delete();
        end
        refresh();
    endtask

    function automatic int pending();
        int n = exp_up.size() + usbq.size();
        for (int i = 0; i < NP; i++) n += exp_tx[i].size() + rxq[i].size();
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (pending() != 0 && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(pending()), 32'd0);
        repeat (2) tick();
    endtask

    // Output monitor: sample flags and check data away from the edge.
    always @(negedge clk) begin
        usb_pop = usb_rx_rden;
        rx_pop  = periph_rx_rden;
        check("usb_rx_rden_on_empty", 32'(usb_rx_rden & usb_rx_empty), 32'd0);
        check("rx_rden_on_empty", 32'(|(periph_rx_rden & periph_rx_empty)), 32'd0);
        check("tx_wren_onehot", 32'($countones(periph_tx_wren) <= 1), 32'd1);
        check("rx_rden_onehot", 32'($countones(periph_rx_rden) <= 1), 32'd1);
        for (int a = 0; a < NP; a++) begin
            if (periph_tx_wren[a]) begin
                if (exp_tx[a].size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: periph %0d got 0x%0h expected nothing", a, periph_tx_data[a]);
                end else begin
                    check("tx_data", 32'(periph_tx_data[a]), 32'(exp_tx[a].pop_front()));
                end
            end
        end
        if (usb_tx_wren) begin
            if (exp_up.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL usb_tx_unexpected: got 0x%0h expected nothing", usb_tx_data);
            end else begin
                check("usb_tx_data", usb_tx_data, exp_up.pop_front());
            end
        end
    end

    // FIFO models advance just after the edge the DUT popped on.
    always @(posedge clk) begin
        #1;
        if (usb_pop && usbq.size() != 0) void'(usbq.pop_front());
        for (int i = 0; i < NP; i++) begin
            if (rx_pop[i] && rxq[i].size() != 0) void'(rxq[i].pop_front());
        end
        usb_pop = 1'b0;
        rx_pop  = '0;
        refresh();
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [31:0] held;
        vecs[0] = '{3'd2, 29'h00000AB,  8'b0000_0100};
        vecs[1] = '{3'd0, 29'h1FFFFFFF, 8'b0000_0001};
        vecs[2] = '{3'd7, 29'h0000000,  8'b1000_0000};
        vecs[3] = '{3'd5, 29'h15555555, 8'b0010_0000};
        vecs[4] = '{3'd1, 29'h0AAAAAAA, 8'b0000_0010};
        vecs[5] = '{3'd6, 29'h0000123,  8'b0100_0000};

        rst = 1'b1;
        usb_pop = 1'b0;
        rx_pop = '0;
        periph_tx_full = '0;
        usb_tx_full = 1'b0;
        usb4_rx_data = 32'h0;
        usb4_rx_empty = 1'b1;
        refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tx_wren", 32'(periph_tx_wren), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_usb_tx_wren", 32'(usb_tx_wren), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // Table: single packets, one-cycle latency, single pulse, broadcast.
        for (int v = 0; v < 6; v++) begin
            push_usb(vecs[v].addr, vecs[v].payload);
            @(negedge clk);
            check("dn_pop", 32'(usb_rx_rden), 32'd1);
            check("dn_lat0_wren", 32'(periph_tx_wren), 32'd0);
            @(negedge clk);
            check("dn_wren", 32'(periph_tx_wren), 32'(vecs[v].exp_wren));
            check("dn_broadcast", 32'(periph_tx_data[0]), 32'(vecs[v].payload));
            @(negedge clk);
            check("dn_single_pulse", 32'(periph_tx_wren), 32'd0);
            tick();
        end

        // Head-of-line blocking on a full peripheral.
        periph_tx_full[2] = 1'b1;
        push_usb(3'd2, 29'h222);
        push_usb(3'd1, 29'h111);
        repeat (5) begin
            @(negedge clk);
            check("blocked_wren", 32'(periph_tx_wren), 32'd0);
        end
        tick();
        periph_tx_full[2] = 1'b0;
        @(negedge clk);
        check("unblock_wren2", 32'(periph_tx_wren), 32'h04);
        check("unblock_pop", 32'(usb_rx_rden), 32'd1);
        @(negedge clk);
        check("next_wren1", 32'(periph_tx_wren), 32'h02);
        @(negedge clk);
        check("after_wren", 32'(periph_tx_wren), 32'd0);
        drain("drain_hol");

        // Round-robin over 0,1,3 with two words each.
        push_rx(0, 29'h0A1); push_rx(1, 29'h1A1); push_rx(3, 29'h3A1);
        push_rx(0, 29'h0A2); push_rx(1, 29'h1A2); push_rx(3, 29'h3A2);
        @(negedge clk);
        check("rr_first_grant", 32'(periph_rx_rden), 32'h01);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("rr_back_to_back", 32'(usb_tx_wren), 32'd1);
        end
        @(negedge clk);
        check("rr_done", 32'(usb_tx_wren), 32'd0);
        drain("drain_rr");

        // Backpressure from the host-bound FIFO mid-stream.
        push_rx(5, 29'h5B1); push_rx(2, 29'h2B1);
        push_rx(5, 29'h5B2); push_rx(2, 29'h2B2);
        push_rx(5, 29'h5B3); push_rx(2, 29'h2B3);
        @(negedge clk);
        check("bp_first_grant", 32'(periph_rx_rden), 32'h20);
        @(negedge clk);
        @(negedge clk);
        tick();
        usb_tx_full = 1'b1;
        held = exp_up[0];
        repeat (3) begin
            @(negedge clk);
            check("bp_no_wren", 32'(usb_tx_wren), 32'd0);
            check("bp_held_data", usb_tx_data, held);
            check("bp_no_rx_rden", 32'(periph_rx_rden), 32'd0);
        end
        tick();
        usb_tx_full = 1'b0;
        drain("drain_bp");

        // Invalid addresses on the 4-peripheral instance.
        usb4_rx_data = 32'hC000_0000;
        usb4_rx_empty = 1'b0;
        @(negedge clk);
        check("inv_pop", 32'(usb4_rx_rden), 32'd1);
        tick();
        usb4_rx_empty = 1'b1;
        @(negedge clk);
        check("inv_drop1", 32'(drop4), 32'd1);
        check("inv_no_wren", 32'(tx4_wren), 32'd0);
        tick();
        usb4_rx_empty = 1'b0;
        repeat (100) @(posedge clk);
        @(negedge clk);
        check("inv_drop101", 32'(drop4), 32'd101);
        check("inv_stream_no_wren", 32'(tx4_wren), 32'd0);
        repeat (199) @(posedge clk);
        #2;
        usb4_rx_empty = 1'b1;
        @(negedge clk);
        check("inv_drop_sat", 32'(drop4), 32'd255);
        tick();
        usb4_rx_data = 32'h6000_0012;
        usb4_rx_empty = 1'b0;
        tick();
        usb4_rx_empty = 1'b1;
        @(negedge clk);
        check("n4_valid_wren", 32'(tx4_wren), 32'h8);
        check("n4_valid_data", 32'(tx4_data[3]), 32'h12);
        check("n4_drop_hold", 32'(drop4), 32'd255);
        tick();

        // Reset with both stages holding packets.
        periph_tx_full[0] = 1'b1;
        usb_tx_full = 1'b1;
        push_usb(3'd0, 29'h0AA);
        push_usb(3'd3, 29'h333);
        push_rx(4, 29'h444);
        repeat (3) tick();
        @(negedge clk);
        check("stuck_no_pop", 32'(usb_rx_rden), 32'd0);
        check("stuck_not_idle", 32'(idle), 32'd0);
        tick();
        #1;
        rst = 1'b1;
        clear_all();
        periph_tx_full = '0;
        usb_tx_full = 1'b0;
        push_usb(3'd3, 29'h333);
        push_rx(5, 29'h5C5);
        push_rx(0, 29'h0C0);
        exp_up.delete();
        exp_up.push_back({3'd0, 29'h0C0});
        exp_up.push_back({3'd5, 29'h5C5});
        #1;
        check("rst_now_tx_wren", 32'(periph_tx_wren), 32'd0);
        check("rst_now_usb_rden", 32'(usb_rx_rden), 32'd0);
        check("rst_now_rx_rden", 32'(periph_rx_rden), 32'd0);
        check("rst_now_usb_wren", 32'(usb_tx_wren), 32'd0);
        @(negedge clk);
        check("rst_drop4_clear", 32'(drop4), 32'd0);
        check("rst_held_rx_rden", 32'(periph_rx_rden), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_grant0", 32'(periph_rx_rden), 32'h01);
        check("post_rst_pop", 32'(usb_rx_rden), 32'd1);
        drain("drain_rst");
        @(negedge clk);
        check("end_idle", 32'(idle), 32'd1);
        check("end_queues", 32'(pending()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
